axi_lite_to_apb_bridge: RTL and testbench
=========================================

Name: axi_lite_to_apb_bridge

Overview:
- Converts the SoC AXI4-Lite peripheral bus into a single APB3/APB4 master port that feeds the SoC peripheral subsystem.
- Sits directly downstream of the SoC interconnect's AXI-to-AXI-Lite converter.
- Serialises reads and writes: one APB transfer in flight at a time, with fair read/write arbitration.
- A programmable PREADY timeout keeps a hung peripheral from locking the bus.

Parameters:
- ADDR_WIDTH, 32, AXI/APB address width.
- DATA_WIDTH, 32, AXI/APB data width. Only 32 is supported.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before forced SLVERR. 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- aw_addr_i  in  ADDR_WIDTH  AXI-Lite write address.
- aw_prot_i  in  3  write protection attributes.
- aw_valid_i  in  1 / aw_ready_o  out  1  AW handshake.
- w_data_i  in  DATA_WIDTH  write data.
- w_strb_i  in  DATA_WIDTH/8  write strobes.
- w_valid_i  in  1 / w_ready_o  out  1  W handshake.
- b_resp_o  out  2 / b_valid_o  out  1 / b_ready_i  in  1  write response channel.
- ar_addr_i  in  ADDR_WIDTH  read address.
- ar_prot_i  in  3  read protection attributes.
- ar_valid_i  in  1 / ar_ready_o  out  1  AR handshake.
- r_data_o  out  DATA_WIDTH / r_resp_o  out  2 / r_valid_o  out  1 / r_ready_i  in  1  read data channel.
- paddr_o  out  ADDR_WIDTH  APB address.
- pprot_o  out  3  APB protection attributes.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction (1 = write).
- pwdata_o  out  DATA_WIDTH  APB write data.
- pstrb_o  out  DATA_WIDTH/8  APB write strobes.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB slave error.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE.
  - Priority flag = write-first.
  - Timeout counter = 0.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A write is eligible only when aw_valid_i && w_valid_i are both high. AW and W are then accepted in the same cycle (aw_ready_o = w_ready_o = 1 combinationally for that cycle only).
  - A read is eligible when ar_valid_i is high.
  - If both are eligible, the direction opposite to the last served one wins (round-robin). The winner updates the flag.
  - The accepted addr/prot/data/strb are registered, then the FSM moves to SETUP.
  - aw_ready_o, w_ready_o and ar_ready_o are 0 in every state other than IDLE.
- SETUP:
  - psel_o = 1, penable_o = 0. Address, control and data come from the registers.
  - pstrb_o = registered strb for writes and 0 for reads.
  - Always exactly one cycle; next state is ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1; the counter increments each cycle.
  - On pready_i = 1: capture prdata_i (reads only) and pslverr_i, then go to RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with pready_i still low: capture error = 1 and rdata = 0, then go to RESP. psel_o and penable_o drop in the next cycle.
  - The counter clears on leaving ACCESS.
- RESP:
  - psel_o = penable_o = 0.
  - For a write, b_valid_o = 1; for a read, r_valid_o = 1 with r_data_o = captured data.
  - resp = 2'b10 (SLVERR) if pslverr or timeout, else 2'b00 (OKAY).
  - Valid is held with stable payload until the matching ready is seen, then the FSM returns to IDLE. A new request cannot be accepted in that same cycle.
- Latency: request accepted at cycle N gives SETUP at N+1 and ACCESS at N+2. With a zero-wait pready, valid asserts at N+3. Back-to-back throughput is one transfer per 4 cycles minimum.
- AW without W (or the reverse) is never partially accepted; it waits in IDLE.
- APB outputs are stable across SETUP→ACCESS and throughout ACCESS wait states.
- pslverr_i is sampled only in the cycle where pready_i = 1.
- Reset asserted mid-transfer returns to IDLE immediately. Any pending response is dropped, and psel_o/penable_o deassert asynchronously.

Test Plan:
- Single write: AW 0x1A10_1004 with W 0xDEAD_BEEF, strb 0xF, pready tied 1 → psel at N+1, penable at N+2, pwdata 0xDEADBEEF; b_valid at N+3 with resp 00.
- Single read, 3 wait states: AR 0x1A10_2000, pready rises on the 4th ACCESS cycle with prdata 0x1234_5678 → r_data 0x12345678, resp 00; r_valid held while r_ready = 0 for 5 cycles.
- Simultaneous AR and AW+W held continuously after reset → order W, R, W, R; each served once per response.
- pslverr = 1 with pready on a read → r_resp 10; r_data = prdata.
- TIMEOUT_CYCLES = 8, pready stuck at 0 → exactly 8 ACCESS cycles, then r_resp 10, r_data 0; the next request proceeds normally.
- Reset asserted during ACCESS → psel/penable go to 0 the same cycle; no b_valid/r_valid after release; the following write completes with resp OKAY.

Source files
------------

// File: rtl/axi_lite_to_apb_bridge.sv
// AXI4-Lite slave to APB3/APB4 master, one transfer in flight, round-robin read/write arbitration.
// Accept at N, SETUP N+1, ACCESS N+2, response valid N+3 at the earliest; requests wait in IDLE while a response is stalled.
module axi_lite_to_apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [2:0]              aw_prot_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [2:0]              ar_prot_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              prot_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    write_q, err_q, prio_wr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    grant_wr, grant_rd, timeout;

  // Both eligible: the direction not served last wins
  assign grant_wr = aw_valid_i && w_valid_i && (!ar_valid_i || prio_wr_q);
  assign grant_rd = ar_valid_i && !grant_wr;

  always_comb begin
    state_d    = state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    ar_ready_o = 1'b0;
    psel_o     = 1'b0;
    penable_o  = 1'b0;
    b_valid_o  = 1'b0;
    r_valid_o  = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          aw_ready_o = 1'b1;
          w_ready_o  = 1'b1;
          state_d    = SETUP;
        end else if (grant_rd) begin
          ar_ready_o = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        psel_o  = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
        if (pready_i) begin
          state_d = RESP;
        end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        b_valid_o = write_q;
        r_valid_o = !write_q;
        if (write_q ? b_ready_i : r_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prio_wr_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_wr) begin
        addr_q    <= aw_addr_i;
        prot_q    <= aw_prot_i;
        wdata_q   <= w_data_i;
        strb_q    <= w_strb_i;
        write_q   <= 1'b1;
        prio_wr_q <= 1'b0;
      end else if (state_q == IDLE && grant_rd) begin
        addr_q    <= ar_addr_i;
        prot_q    <= ar_prot_i;
        write_q   <= 1'b0;
        prio_wr_q <= 1'b1;
      end
      if (state_q == ACCESS) begin
        cnt_q <= (state_d == ACCESS) ? cnt_q + 1'b1 : '0;
        if (pready_i) begin
          err_q <= pslverr_i;
          if (!write_q) rdata_q <= prdata_i;
        end else if (timeout) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign paddr_o  = addr_q;
  assign pprot_o  = prot_q;
  assign pwrite_o = write_q;
  assign pwdata_o = wdata_q;
  assign pstrb_o  = write_q ? strb_q : '0;
  assign b_resp_o = {err_q, 1'b0};
  assign r_resp_o = {err_q, 1'b0};
  assign r_data_o = rdata_q;

endmodule

// File: tb/tb_axi_lite_to_apb_bridge.sv
// Bench for axi_lite_to_apb_bridge: directed scenarios plus randomized transfers against a transaction-level model.
module tb_axi_lite_to_apb_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] aw_addr, w_data, ar_addr, r_data, paddr, pwdata, prdata;
  logic [2:0]  aw_prot, ar_prot, pprot;
  logic [3:0]  w_strb, pstrb;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [1:0]  b_resp, r_resp;
  logic        psel, penable, pwrite, pready, pslverr;

  int n_chk = 0;
  int n_err = 0;
  bit prio_wr;

  always #5 clk = ~clk;

  axi_lite_to_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_psel", psel, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_b_valid", b_valid, 0);
    check_eq("rst_r_valid", r_valid, 0);
    check_eq("rst_readies", {aw_ready, w_ready, ar_ready}, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_pwdata", pwdata, 0);
    check_eq("rst_r_data", r_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prio_wr = 1'b1;
  endtask

  // One complete transfer, starting and ending at a negedge with the bridge idle.
  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input bit err, input logic [31:0] prd, input int rdy_delay);
    bit          timed_out;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          k;
    timed_out = (waits >= TO);
    exp_resp  = (timed_out || err) ? 2'b10 : 2'b00;
    exp_data  = timed_out ? 32'h0 : prd;

    if (is_wr) begin
      aw_addr = addr; aw_prot = prot; w_data = data; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1;
    end else begin
      ar_addr = addr; ar_prot = prot; ar_valid = 1'b1;
    end
    pready = 1'b0;
    #1;
    check_eq("accept_ready", {aw_ready, w_ready, ar_ready}, is_wr ? 3'b110 : 3'b001);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    check_eq("setup_sel_en", {psel, penable}, 2'b10);
    check_eq("setup_paddr", paddr, addr);
    check_eq("setup_pwrite", pwrite, is_wr);
    check_eq("setup_pprot", pprot, prot);
    check_eq("setup_pstrb", pstrb, is_wr ? strb : 4'h0);
    if (is_wr) check_eq("setup_pwdata", pwdata, data);

    k = 0;
    forever begin
      @(negedge clk);
      check_eq("access_sel_en", {psel, penable}, 2'b11);
      check_eq("access_paddr", paddr, addr);
      if (is_wr) check_eq("access_pwdata", pwdata, data);
      pready  = (k == waits);
      pslverr = (k == waits) ? err : 1'($urandom);
      prdata  = (k == waits) ? prd : $urandom;
      if (k == waits || k == TO - 1) break;
      k++;
    end

    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0;
    check_eq("resp_sel_en", {psel, penable}, 2'b00);
    check_eq("resp_valids", {b_valid, r_valid}, is_wr ? 2'b10 : 2'b01);
    if (is_wr) check_eq("b_resp", b_resp, exp_resp);
    else begin
      check_eq("r_resp", r_resp, exp_resp);
      check_eq("r_data", r_data, exp_data);
    end
    for (int i = 0; i < rdy_delay; i++) @(negedge clk);
    if (rdy_delay > 0) begin
      check_eq("hold_valids", {b_valid, r_valid}, is_wr ? 2'b10 : 2'b01);
      check_eq("hold_resp", is_wr ? b_resp : r_resp, exp_resp);
      if (!is_wr) check_eq("hold_r_data", r_data, exp_data);
    end
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    check_eq("done_valids", {b_valid, r_valid}, 2'b00);
    prio_wr = !is_wr;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    aw_addr = '0; aw_prot = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0;
    ar_addr = '0; ar_prot = '0; ar_valid = 0; b_ready = 0; r_ready = 0;
    prdata = '0; pready = 0; pslverr = 0;
    apply_reset();

    run_txn(1, 32'h1A10_1004, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 0, 32'h0, 0);
    run_txn(0, 32'h1A10_2000, 32'h0, 4'h0, 3'd2, 3, 0, 32'h1234_5678, 5);
    run_txn(0, 32'h1A10_2004, 32'h0, 4'h0, 3'd1, 0, 1, 32'hCAFE_F00D, 1);
    run_txn(0, 32'h1A10_3000, 32'h0, 4'h0, 3'd0, 50, 0, 32'h5555_AAAA, 0);
    run_txn(1, 32'h1A10_3004, 32'h0BAD_0BAD, 4'h5, 3'd4, 2, 0, 32'h0, 2);

    // Half a write request must never be accepted
    aw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("aw_only_ready", {aw_ready, w_ready, psel}, 3'b000);
    end
    aw_valid = 1'b0; w_valid = 1'b1;
    @(negedge clk);
    check_eq("w_only_ready", {aw_ready, w_ready, psel}, 3'b000);
    w_valid = 1'b0;

    // Both directions held continuously after reset
    apply_reset();
    aw_addr = 32'h0000_1000; w_data = 32'h1111_2222; w_strb = 4'hF; aw_prot = 3'd0;
    ar_addr = 32'h0000_2000; ar_prot = 3'd0;
    aw_valid = 1; w_valid = 1; ar_valid = 1; pready = 1;
    for (int i = 0; i < 4; i++) begin
      bit exp_wr;
      exp_wr = prio_wr;
      #1;
      check_eq("arb_ready", {aw_ready, ar_ready}, exp_wr ? 2'b10 : 2'b01);
      @(negedge clk);
      check_eq("arb_pwrite", pwrite, exp_wr);
      check_eq("arb_paddr", paddr, exp_wr ? 32'h0000_1000 : 32'h0000_2000);
      @(negedge clk);
      @(negedge clk);
      check_eq("arb_valids", {b_valid, r_valid}, exp_wr ? 2'b10 : 2'b01);
      check_eq("arb_no_accept_in_resp", {aw_ready, ar_ready}, 2'b00);
      b_ready = 1; r_ready = 1;
      @(negedge clk);
      b_ready = 0; r_ready = 0;
      prio_wr = !exp_wr;
    end
    aw_valid = 0; w_valid = 0; ar_valid = 0; pready = 0;

    // Reset during ACCESS
    aw_addr = 32'h0000_3000; w_data = 32'h7777_8888; aw_valid = 1; w_valid = 1;
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
    @(negedge clk);
    check_eq("pre_rst_access", {psel, penable}, 2'b11);
    #1 rst_n = 1'b0;
    #1 check_eq("async_rst_sel_en", {psel, penable}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    prio_wr = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_no_valid", {b_valid, r_valid, psel}, 3'b000);
    end
    pready = 1'b0;
    run_txn(1, 32'h0000_3004, 32'h9999_0000, 4'hF, 3'd0, 1, 0, 32'h0, 0);

    // Randomized transfers
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
              $urandom_range(0, 11), 1'($urandom_range(0, 3) == 0), $urandom,
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
